// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, opcodes,
// ALU operation classes and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        UPPER    = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10,
        JALR_ADR = 4'd11,
        JAL      = 4'd12,
        TRAP     = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_RFN = 3'b010;
    localparam logic [2:0] ALU_IFN = 3'b011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    function automatic logic is_wait_state(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory request; expire_o flags the cycle on which
// the count has reached WAIT_LIMIT (never when WAIT_LIMIT is 0).
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expire_o
);
    localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Saturate so a disabled limit can never wrap back onto a stale match.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (WAIT_LIMIT != 0) && (cnt_q == CW'(WAIT_LIMIT));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: Moore state decode with mem_ready qualifying
// the fetch strobes, sticky illegal/timeout traps and a retired-instruction count.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W   = 3,
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          result_src,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                illegal,
    output logic                timeout,
    output logic [CNT_W-1:0]    retired,
    output logic [3:0]          state_o
);
    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             waiting_s, expire_s, wait_trap_s;
    logic [2:0]       alu_op_s;

    assign waiting_s   = is_wait_state(state_q);
    assign wait_trap_s = waiting_s && expire_s && !mem_ready;

    // Any state change clears the timer, which covers entry to every wait state.
    mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_d != state_q),
        .inc_i    (waiting_s && !mem_ready),
        .expire_o (expire_s)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            FETCH, MEMRD, MEMWR: begin
                if (wait_trap_s) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else if (mem_ready) begin
                    state_d = (state_q == FETCH) ? DECODE :
                              (state_q == MEMRD) ? MEMWB  : FETCH;
                end else begin
                    state_d = state_q;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_R:              state_d = EXECR;
                    OP_I:              state_d = EXECI;
                    OP_BEQ:            state_d = BEQ;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR_ADR;
                    OP_LUI, OP_AUIPC:  state_d = UPPER;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:              state_d = (opcode == OP_STORE) ? MEMWR : MEMRD;
            MEMWB, ALUWB, BEQ:   state_d = FETCH;
            EXECR, EXECI, UPPER: state_d = ALUWB;
            JALR_ADR:            state_d = JAL;
            JAL:                 state_d = ALUWB;
            TRAP:                state_d = TRAP;
            default:             state_d = TRAP;
        endcase
        if ((state_d == FETCH) && (state_q != FETCH)) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            retired_q <= retired_d;
        end
    end

    // All-zero defaults select PC / rs2 / ALUOut / add.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        alu_op_s      = ALU_ADD;
        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            MEMADR, JALR_ADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
            end
            MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
            end
            EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_op_s  = ALU_RFN;
            end
            EXECI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op_s  = ALU_IFN;
            end
            UPPER: begin
                alu_src_a = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            BEQ: begin
                alu_src_a     = SRCA_RS1;
                alu_op_s      = ALU_SUB;
                pc_write_cond = 1'b1;
            end
            JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            TRAP:    mem_req = 1'b0;
            default: mem_req = 1'b0;
        endcase
    end

    assign alu_op  = ALU_OP_W'(alu_op_s);
    assign illegal = illegal_q;
    assign timeout = timeout_q;
    assign retired = retired_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (WAIT_LIMIT=4, CNT_W=4) with hand-computed expectations.
module tb_multicycle_control;

    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2, ST_MEMRD = 4'd3,
                           ST_MEMWB = 4'd4, ST_MEMWR = 4'd5, ST_EXECR = 4'd6, ST_UPPER = 4'd8,
                           ST_ALUWB = 4'd9, ST_BEQ = 4'd10, ST_JALR_ADR = 4'd11, ST_JAL = 4'd12,
                           ST_TRAP = 4'd13;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_op;
    logic       illegal, timeout;
    logic [3:0] retired;
    logic [3:0] state_o;
    logic [6:0] strobes;

    int checks = 0;
    int failures = 0;

    multicycle_control #(.ALU_OP_W(3), .WAIT_LIMIT(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .illegal(illegal), .timeout(timeout), .retired(retired),
        .state_o(state_o)
    );

    // {mem_req, mem_we, adr_src, ir_write, pc_write, pc_write_cond, reg_write}
    assign strobes = {mem_req, mem_we, adr_src, ir_write, pc_write, pc_write_cond, reg_write};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_state", 32'(state_o), 32'(ST_FETCH));
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] up_ops [2];
        logic [1:0] up_a [2];
        up_ops[0] = 7'b0110111; up_a[0] = 2'b11;
        up_ops[1] = 7'b0010111; up_a[1] = 2'b01;

        @(posedge clk);
        do_reset();

        // R-type, zero-wait memory
        opcode = 7'b0110011; mem_ready = 1'b1; #1;
        chk("r_fetch_state", 32'(state_o), 32'(ST_FETCH));
        chk("r_fetch_strb", 32'(strobes), 32'b1001100);
        chk("r_fetch_srcb", 32'(alu_src_b), 32'd2);
        chk("r_fetch_res", 32'(result_src), 32'd2);
        cyc();
        chk("r_dec_state", 32'(state_o), 32'(ST_DECODE));
        chk("r_dec_srca", 32'(alu_src_a), 32'd1);
        chk("r_dec_srcb", 32'(alu_src_b), 32'd1);
        chk("r_dec_strb", 32'(strobes), 32'd0);
        cyc();
        chk("r_ex_state", 32'(state_o), 32'(ST_EXECR));
        chk("r_ex_aluop", 32'(alu_op), 32'd2);
        chk("r_ex_srca", 32'(alu_src_a), 32'd2);
        chk("r_ex_strb", 32'(strobes), 32'd0);
        cyc();
        chk("r_wb_state", 32'(state_o), 32'(ST_ALUWB));
        chk("r_wb_strb", 32'(strobes), 32'b0000001);
        chk("r_wb_res", 32'(result_src), 32'd0);
        cyc();
        chk("r_done_state", 32'(state_o), 32'(ST_FETCH));
        chk("r_retired", 32'(retired), 32'd1);

        // Load with three stall cycles in MEMRD
        opcode = 7'b0000011; cyc();
        cyc();
        chk("ld_adr_state", 32'(state_o), 32'(ST_MEMADR));
        chk("ld_adr_srca", 32'(alu_src_a), 32'd2);
        chk("ld_adr_srcb", 32'(alu_src_b), 32'd1);
        cyc();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            chk("ld_rd_state", 32'(state_o), 32'(ST_MEMRD));
            chk("ld_rd_strb", 32'(strobes), 32'b1010000);
            cyc();
        end
        chk("ld_wb_state", 32'(state_o), 32'(ST_MEMWB));
        chk("ld_wb_res", 32'(result_src), 32'd1);
        chk("ld_wb_strb", 32'(strobes), 32'b0000001);
        cyc();
        chk("ld_retired", 32'(retired), 32'd2);

        // JALR
        opcode = 7'b1100111; cyc();
        cyc();
        chk("jalr_adr_state", 32'(state_o), 32'(ST_JALR_ADR));
        chk("jalr_adr_srca", 32'(alu_src_a), 32'd2);
        cyc();
        chk("jal_state", 32'(state_o), 32'(ST_JAL));
        chk("jal_strb", 32'(strobes), 32'b0000100);
        chk("jal_srca", 32'(alu_src_a), 32'd1);
        chk("jal_srcb", 32'(alu_src_b), 32'd2);
        cyc();
        chk("jal_wb_strb", 32'(strobes), 32'b0000001);
        cyc();
        chk("jalr_done_state", 32'(state_o), 32'(ST_FETCH));
        chk("jalr_retired", 32'(retired), 32'd3);

        // LUI then AUIPC: A select differs
        for (int k = 0; k < 2; k++) begin
            opcode = up_ops[k]; cyc();
            cyc();
            chk("up_state", 32'(state_o), 32'(ST_UPPER));
            chk("up_srca", 32'(alu_src_a), 32'(up_a[k]));
            chk("up_srcb", 32'(alu_src_b), 32'd1);
            cyc();
            cyc();
        end
        chk("up_retired", 32'(retired), 32'd5);

        // Illegal opcode traps and stays quiet
        opcode = 7'b1111111; cyc();
        chk("ill_dec_flag", 32'(illegal), 32'd0);
        cyc();
        chk("ill_state", 32'(state_o), 32'(ST_TRAP));
        chk("ill_flag", 32'(illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #1;
            chk("trap_strb", 32'(strobes), 32'd0);
            cyc();
        end
        chk("trap_hold", 32'(state_o), 32'(ST_TRAP));
        do_reset();

        // 17 beq wrap the 4-bit counter to 1
        opcode = 7'b1100011; mem_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            #1;
            chk("beq_fetch", 32'(state_o), 32'(ST_FETCH));
            cyc();
            cyc();
            if (k == 0) begin
                chk("beq_state", 32'(state_o), 32'(ST_BEQ));
                chk("beq_strb", 32'(strobes), 32'b0000010);
                chk("beq_aluop", 32'(alu_op), 32'd1);
                chk("beq_srca", 32'(alu_src_a), 32'd2);
            end
            cyc();
        end
        chk("beq_wrap", 32'(retired), 32'd1);

        // Reset while a store waits in MEMWR
        opcode = 7'b0100011; cyc();
        cyc();
        cyc();
        mem_ready = 1'b0; #1;
        chk("st_wr_state", 32'(state_o), 32'(ST_MEMWR));
        chk("st_wr_strb", 32'(strobes), 32'b1110000);
        do_reset();
        #1;
        chk("post_rst_strb", 32'(strobes), 32'b1000000);
        chk("post_rst_state", 32'(state_o), 32'(ST_FETCH));

        // Timeout in FETCH after four stall cycles
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("to_wait_state", 32'(state_o), 32'(ST_FETCH));
            chk("to_wait_strb", 32'(strobes), 32'b1000000);
            cyc();
        end
        chk("to_state", 32'(state_o), 32'(ST_TRAP));
        chk("to_flag", 32'(timeout), 32'd1);
        chk("to_illegal", 32'(illegal), 32'd0);
        do_reset();

        // Ready arrives exactly on the limit cycle
        for (int i = 0; i < 4; i++) cyc();
        mem_ready = 1'b1; #1;
        chk("lim_state", 32'(state_o), 32'(ST_FETCH));
        chk("lim_strb", 32'(strobes), 32'b1001100);
        cyc();
        chk("lim_decode", 32'(state_o), 32'(ST_DECODE));
        chk("lim_no_to", 32'(timeout), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
